// File: rtl/sdram_phase_pkg.sv
// Shared types and default timing constants for the SDRAM clock-phase sweep.
package sdram_phase_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SNAP,
    S_MEASURE,
    S_EVAL,
    S_STEP,
    S_MOVE,
    S_FIN
  } sweep_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_HIGH,
    P_LOW
  } pulse_state_e;

  localparam int unsigned STEPS_DEF   = 64;
  localparam int unsigned SETTLE_DEF  = 65536;
  localparam int unsigned PASSES_DEF  = 2;
  localparam int unsigned TIMEOUT_DEF = 1 << 26;
  localparam int unsigned PULSE_DEF   = 4;

  // Centre of the best window, biased towards its lower end; 0 when no window exists.
  function automatic logic [7:0] window_centre(input logic [7:0] lo, input logic [8:0] len);
    if (len == 9'd0) return 8'd0;
    return lo + 8'((len - 9'd1) >> 1);
  endfunction

endpackage

// File: rtl/phase_step_pulser.sv
// Generates one forward PLL phase step per request: a direction set-up cycle,
// C_pulse high cycles, C_pulse low cycles, then a one-cycle ack.
module phase_step_pulser
  import sdram_phase_pkg::*;
#(
  parameter int unsigned C_pulse = PULSE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic ack_o,
  output logic fall_o,
  output logic phasestep_o,
  output logic phasedir_o
);

  localparam logic [15:0] LAST = 16'(C_pulse - 1);

  pulse_state_e state_q;
  logic [15:0]  cnt_q;
  logic         phasestep_q;
  logic         ack_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= P_IDLE;
      cnt_q       <= '0;
      phasestep_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        P_IDLE: begin
          if (req_i) state_q <= P_SETUP;
        end
        // phasedir is already stable here, one cycle ahead of the rising edge
        P_SETUP: begin
          phasestep_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= P_HIGH;
        end
        P_HIGH: begin
          if (cnt_q == LAST) begin
            phasestep_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= P_LOW;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        P_LOW: begin
          if (cnt_q == LAST) begin
            ack_q   <= 1'b1;
            state_q <= P_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= P_IDLE;
      endcase
    end
  end

  // Asserted in the cycle whose closing edge drops phasestep.
  assign fall_o      = (state_q == P_HIGH) && (cnt_q == LAST);
  assign ack_o       = ack_q;
  assign phasestep_o = phasestep_q;
  assign phasedir_o  = 1'b0;

endmodule

// File: rtl/sdram_phase_sweep.sv
// Sweeps the SDRAM clock phase across a full PLL rotation, scores each position
// with memtester counters, then parks the PLL in the centre of the longest good window.
module sdram_phase_sweep
  import sdram_phase_pkg::*;
#(
  parameter int unsigned C_steps   = STEPS_DEF,
  parameter int unsigned C_settle  = SETTLE_DEF,
  parameter int unsigned C_passes  = PASSES_DEF,
  parameter int unsigned C_timeout = TIMEOUT_DEF,
  parameter int unsigned C_pulse   = PULSE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] passcount,
  input  logic [31:0] failcount,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg,
  output logic [7:0]  phase,
  output logic [7:0]  win_lo,
  output logic [8:0]  win_len,
  output logic        busy,
  output logic        done,
  output logic        nowin
);

  localparam logic [7:0]  PH_MASK      = 8'(C_steps - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(C_settle - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(C_timeout - 1);
  localparam logic [31:0] PASS_TARGET  = 32'(C_passes);

  sweep_state_e state_q;
  logic [31:0]  cnt_q;
  logic [31:0]  base_pass_q;
  logic [31:0]  base_fail_q;
  logic [8:0]   run_q;
  logic [7:0]   win_lo_q;
  logic [8:0]   win_len_q;
  logic [7:0]   phase_q;
  logic [7:0]   moves_q;
  logic         good_q;
  logic         moving_q;
  logic         req_q;
  logic         busy_q;
  logic         done_q;
  logic         nowin_q;

  logic         pulse_ack;
  logic         step_fall;
  logic [31:0]  pass_delta;
  logic [8:0]   run_inc;

  // Modulo-2^32 difference keeps a wrapping memtester counter usable.
  assign pass_delta = passcount - base_pass_q;
  assign run_inc    = run_q + 9'd1;

  phase_step_pulser #(
    .C_pulse(C_pulse)
  ) u_pulser (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_q),
    .ack_o      (pulse_ack),
    .fall_o     (step_fall),
    .phasestep_o(phasestep),
    .phasedir_o (phasedir)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_pass_q <= '0;
      base_fail_q <= '0;
      run_q       <= '0;
      win_lo_q    <= '0;
      win_len_q   <= '0;
      phase_q     <= '0;
      moves_q     <= '0;
      good_q      <= 1'b0;
      moving_q    <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nowin_q     <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (step_fall) phase_q <= (phase_q + 8'd1) & PH_MASK;

      case (state_q)
        // The physical phase at start becomes logical position 0 for this sweep.
        S_IDLE: begin
          if (start) begin
            win_lo_q  <= '0;
            win_len_q <= '0;
            run_q     <= '0;
            phase_q   <= '0;
            cnt_q     <= '0;
            moving_q  <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            nowin_q   <= 1'b0;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= moving_q ? S_MOVE : S_SNAP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_SNAP: begin
          base_pass_q <= passcount;
          base_fail_q <= failcount;
          cnt_q       <= '0;
          state_q     <= S_MEASURE;
        end
        S_MEASURE: begin
          if (pass_delta >= PASS_TARGET) begin
            good_q  <= (failcount == base_fail_q);
            state_q <= S_EVAL;
          end else if (cnt_q == TIMEOUT_LAST) begin
            good_q  <= 1'b0;
            state_q <= S_EVAL;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        // Strictly-greater keeps the earliest of equally long windows.
        S_EVAL: begin
          if (good_q) begin
            run_q <= run_inc;
            if (run_inc > win_len_q) begin
              win_len_q <= run_inc;
              win_lo_q  <= phase_q - 8'(run_inc) + 8'd1;
            end
          end else begin
            run_q <= '0;
          end
          if (phase_q == PH_MASK) begin
            state_q <= S_MOVE;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          if (pulse_ack) begin
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end
        end
        // First visit computes the forward distance; later visits issue one step each.
        S_MOVE: begin
          if (!moving_q) begin
            moving_q <= 1'b1;
            moves_q  <= (window_centre(win_lo_q, win_len_q) - phase_q) & PH_MASK;
          end else if (moves_q == 8'd0) begin
            state_q <= S_FIN;
          end else begin
            moves_q <= moves_q - 8'd1;
            req_q   <= 1'b1;
            state_q <= S_STEP;
          end
        end
        S_FIN: begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          nowin_q  <= (win_len_q == 9'd0);
          moving_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign phaseloadreg = 1'b0;
  assign phase        = phase_q;
  assign win_lo       = win_lo_q;
  assign win_len      = win_len_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign nowin        = nowin_q;

endmodule

// File: tb/tb_sdram_phase_sweep.sv
// Directed bench for sdram_phase_sweep with an emulated memtester and a window/phase model.
module tb_sdram_phase_sweep;

  localparam int STEPS   = 8;
  localparam int SETTLE  = 4;
  localparam int PASSES  = 2;
  localparam int TIMEOUT = 100;
  localparam int PULSE   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] passcount = 32'd0;
  logic [31:0] failcount = 32'd0;
  logic        phasedir, phasestep, phaseloadreg;
  logic [7:0]  phase, win_lo;
  logic [8:0]  win_len;
  logic        busy, done, nowin;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sdram_phase_sweep #(
    .C_steps  (STEPS),
    .C_settle (SETTLE),
    .C_passes (PASSES),
    .C_timeout(TIMEOUT),
    .C_pulse  (PULSE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .passcount   (passcount),
    .failcount   (failcount),
    .phasedir    (phasedir),
    .phasestep   (phasestep),
    .phaseloadreg(phaseloadreg),
    .phase       (phase),
    .win_lo      (win_lo),
    .win_len     (win_len),
    .busy        (busy),
    .done        (done),
    .nowin       (nowin)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Memtester stand-in: +2 passes per cycle when running, +1 fail per cycle on a bad position.
  logic        fast = 1'b1;
  logic [7:0]  good_mask = 8'hFF;
  logic        pc_load = 1'b0;
  logic [31:0] pc_val = 32'd0;

  always @(posedge clk) begin
    #1;
    if (pc_load) begin
      passcount = pc_val;
      pc_load   = 1'b0;
    end else if (fast) begin
      passcount = passcount + 32'd2;
    end
    if (!good_mask[phase[2:0]]) failcount = failcount + 32'd1;
  end

  // Per-cycle observer: expected logical phase follows reset, accepted start and phasestep falls.
  int         cyc = 0;
  logic       rst_p = 1'b0, start_p = 1'b0, busy_p = 1'b0, ps_p = 1'b0;
  logic [7:0] m_phase = 8'd0;
  int         hi_len = 0;
  int         rises = 0;
  int         rise1_t = 0;
  int         gap01 = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_p || (start_p && !busy_p)) begin
      m_phase = 8'd0;
      rises   = 0;
    end else if (ps_p && !phasestep) begin
      m_phase = 8'((int'(m_phase) + 1) % STEPS);
    end
    if (rst_p && ps_p && !phasestep) chk("pulse_width", 32'(hi_len), 32'(PULSE));
    if (phasestep) hi_len++;
    else hi_len = 0;
    if (rst_p && phasestep && !ps_p) begin
      rises++;
      if (rises == 1) rise1_t = cyc;
      if (rises == 2) gap01 = cyc - rise1_t;
    end
    chk("phase_track", 32'(phase), 32'(m_phase));
    chk("dir_load_zero", {30'd0, phasedir, phaseloadreg}, 32'd0);
    chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
    rst_p   = rst_n;
    start_p = start;
    busy_p  = busy;
    ps_p    = phasestep;
  end

  // Longest all-good interval by exhaustive search, earliest start on ties.
  function automatic void best_window(input logic [7:0] mask, output int lo, output int len);
    lo  = 0;
    len = 0;
    for (int s = 0; s < STEPS; s++) begin
      for (int l = 1; s + l <= STEPS; l++) begin
        bit ok = 1'b1;
        for (int p = s; p < s + l; p++) if (!mask[p]) ok = 1'b0;
        if (ok && l > len) begin
          lo  = s;
          len = l;
        end
      end
    end
  endfunction

  task automatic check_sweep(input string tag, input logic [7:0] eff);
    int lo, len, tgt, mv;
    best_window(eff, lo, len);
    tgt = (len == 0) ? 0 : lo + (len - 1) / 2;
    mv  = ((tgt - (STEPS - 1)) % STEPS + STEPS) % STEPS;
    chk({tag, "_win_lo"}, 32'(win_lo), 32'(lo));
    chk({tag, "_win_len"}, 32'(win_len), 32'(len));
    chk({tag, "_nowin"}, 32'(nowin), 32'(len == 0));
    chk({tag, "_final_phase"}, 32'(phase), 32'(tgt));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_step_count"}, 32'(rises), 32'((STEPS - 1) + mv));
  endtask

  task automatic pulse_start(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_after_start"}, 32'(done), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(done), 32'd1);
  endtask

  int gap_fast;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_win", {15'd0, win_len, win_lo}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, nowin, phasestep}, 32'd0);
    rst_n = 1'b1;

    // Scenario 1: positions 2..5 good
    good_mask = 8'b0011_1100;
    fast      = 1'b1;
    pulse_start("s1");
    wait_done("s1", 3000);
    check_sweep("s1", good_mask);
    chk("s1_lit_lo", 32'(win_lo), 32'd2);
    chk("s1_lit_len", 32'(win_len), 32'd4);
    chk("s1_lit_phase", 32'(phase), 32'd3);
    chk("s1_lit_steps", 32'(rises), 32'd11);
    gap_fast = gap01;

    // Scenario 2: every position bad
    good_mask = 8'h00;
    pulse_start("s2");
    wait_done("s2", 3000);
    check_sweep("s2", 8'h00);
    chk("s2_lit_nowin", 32'(nowin), 32'd1);
    chk("s2_lit_phase", 32'(phase), 32'd0);
    chk("s2_lit_steps", 32'(rises), 32'd8);

    // Scenario 3: passcount frozen, every measurement times out
    good_mask = 8'hFF;
    fast      = 1'b0;
    pulse_start("s3");
    wait_done("s3", 5000);
    check_sweep("s3", 8'h00);
    chk("s3_lit_nowin", 32'(nowin), 32'd1);
    chk("s3_measure_len", 32'(gap01), 32'(gap_fast + TIMEOUT - 1));
    fast = 1'b1;

    // Scenario 4: reset in the second phasestep-high cycle
    begin
      int n = 0;
      pulse_start("s4");
      while (!phasestep && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      chk("s4_step_seen", 32'(phasestep), 32'd1);
      @(posedge clk); #1;
      chk("s4_second_high", 32'(phasestep), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("s4_rst_phasestep", 32'(phasestep), 32'd0);
      chk("s4_rst_phase", 32'(phase), 32'd0);
      chk("s4_rst_busy", 32'(busy), 32'd0);
      chk("s4_rst_win", 32'(win_len), 32'd0);
      rst_n = 1'b1;
      pulse_start("s4b");
      wait_done("s4b", 3000);
      check_sweep("s4b", 8'hFF);
    end

    // Scenario 5: passcount wraps through 0xFFFFFFFF -> 0x00000001 at varied offsets
    for (int k = 0; k < 25; k++) begin
      good_mask = 8'hFF;
      pc_val    = 32'hFFFF_FFFF - 32'(2 * k);
      pc_load   = 1'b1;
      pulse_start("s5");
      wait_done("s5", 3000);
      check_sweep("s5", 8'hFF);
    end

    // Scenario 6: start while busy is ignored
    good_mask = 8'hFF;
    pulse_start("s6");
    repeat (40) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("s6_still_busy", 32'(busy), 32'd1);
    wait_done("s6", 3000);
    check_sweep("s6", 8'hFF);
    chk("s6_lit_lo", 32'(win_lo), 32'd0);
    chk("s6_lit_len", 32'(win_len), 32'(STEPS));
    chk("s6_lit_phase", 32'(phase), 32'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sdram_phase_sweep.md
SDRAM_PHASE_SWEEP -- requirements
Module: sdram_phase_sweep

Interface
REQ-001 Parameter C_steps, default 64: phase positions per full PLL rotation; power of two, 8..256.
REQ-002 Parameter C_settle, default 65536: clk cycles waited after each phase move before measuring.
REQ-003 Parameter C_passes, default 2: memtester passcount increments required per measurement.
REQ-004 Parameter C_timeout, default 2^26: max clk cycles per measurement before the position is declared bad.
REQ-005 Parameter C_pulse, default 4: phasestep pulse width in clk cycles.
REQ-006 clk  in  1: single clock; all ports synchronous to it; reset is synchronous and active-low.
REQ-007 rst_n  in  1: synchronous active-low reset.
REQ-008 start  in  1: one-cycle request to begin a sweep; ignored while busy.
REQ-009 passcount  in  32: memtester pass counter, already synchronised to clk by the caller.
REQ-010 failcount  in  32: memtester fail counter, already synchronised to clk by the caller.
REQ-011 phasedir  out  1: PLL dynamic phase direction; 0 = advance.
REQ-012 phasestep  out  1: PLL phase step pulse, active high.
REQ-013 phaseloadreg  out  1: PLL load strobe; held 0.
REQ-014 phase  out  8: current logical phase position, 0..C_steps-1.
REQ-015 win_lo / win_len  out  8 / 9: start position and length of the longest good window.
REQ-016 busy / done / nowin  out  1 each: sweep in progress / sweep finished / no good position found.

Function
REQ-017 States: IDLE, SETTLE, SNAP, MEASURE, EVAL, STEP, MOVE, FIN.
REQ-018 IDLE + start: clear window registers, set the run counter to 0, go to SETTLE; busy=1 and done=0 from the next cycle.
REQ-019 SETTLE counts C_settle cycles, then goes to SNAP.
REQ-020 SNAP latches passcount and failcount as the baseline (one cycle), then goes to MEASURE.
REQ-021 MEASURE exits to EVAL when (passcount - base_pass) >= C_passes, or after C_timeout cycles; subtraction is modulo 2^32.
REQ-022 EVAL: a position is good when failcount == base_fail and the pass target was reached without timeout.
REQ-023 Good position: increment the run counter; if run > win_len, set win_len = run and win_lo = phase - run + 1. Bad position: run = 0.
REQ-024 Windows are linear over 0..C_steps-1; no merge across the wrap from C_steps-1 to 0.
REQ-025 EVAL, phase < C_steps-1: go to STEP. phase == C_steps-1: go to MOVE.
REQ-026 STEP: phasedir=0 is held one cycle before phasestep rises; phasestep is high for C_pulse cycles; then the same number of low cycles with phasedir held; phase increments modulo C_steps on phasestep fall; then go to SETTLE.
REQ-027 MOVE: target = win_lo + (win_len-1)/2, or 0 if win_len==0. Issue (target - phase) mod C_steps STEP pulses, each followed by C_settle, then go to FIN. Zero pulses is legal.
REQ-028 FIN: busy=0, done=1 (level, held until the next start); nowin = (win_len==0); return to IDLE.
REQ-029 In IDLE after FIN, a new start re-sweeps from the current phase, which is treated as the reference for positions.
REQ-030 Only forward steps are ever issued; phasedir is constant 0.

Reset
REQ-031 rst_n=0 at any clk edge, including mid-pulse: state=IDLE, phasestep=0, phasedir=0, phaseloadreg=0, phase=0, win_lo=0, win_len=0, busy=0, done=0, nowin=0; all counters cleared.
REQ-032 After reset, the physical PLL phase is defined as logical position 0; the block takes no other action.

Structure
REQ-033 State encoding and default timing constants go in a shared package, sdram_phase_pkg.
REQ-034 One sub-module, phase_step_pulser, implements REQ-026 with a req/ack handshake; the sweep FSM instantiates it once.

Verification
REQ-035 Scenario 1: C_steps=8, C_settle=4; positions 2..5 good, rest with failcount+1 -> win_lo=2, win_len=4, target=3, MOVE issues 4 pulses, phase=3, done=1.
REQ-036 Scenario 2: every position bad -> nowin=1, win_len=0, MOVE issues 1 pulse, phase=0.
REQ-037 Scenario 3: passcount frozen, C_timeout=100 -> each MEASURE lasts exactly 100 cycles, all positions bad, nowin=1.
REQ-038 Scenario 4: rst_n low during the 2nd phasestep-high cycle -> phasestep=0, phase=0, busy=0 on the next edge; start is then accepted.
REQ-039 Scenario 5: passcount wraps 0xFFFFFFFF->0x00000001 in MEASURE with C_passes=2 -> position evaluated good.
REQ-040 Scenario 6: start pulsed while busy -> ignored, sweep result unchanged; all positions good -> win_lo=0, win_len=C_steps.
